// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared arithmetic, S-boxes, key-step helpers and FSM state type.
package aes_pkg;

    typedef enum logic [2:0] {S_IDLE, S_KEYGEN, S_INIT, S_ROUND, S_FINAL} aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        a252 = gmul(a240, a12);
        return gmul(a252, a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte 0 sits in the most significant position.
    function automatic logic [7:0] get_byte(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - Combinational AES inverse round; last_round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] result
);

    logic [127:0] sub_added;
    logic [127:0] mixed;

    // Row r of column c comes from column (c - r) mod 4 of the input.
    always_comb begin
        sub_added = '0;
        for (int i = 0; i < 16; i++) begin
            sub_added[127-8*i -: 8] = inv_sbox(get_byte(state, (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)))
                                      ^ get_byte(round_key, i);
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_column(sub_added[127-32*c -: 32]);
        end
    end

    assign result = last_round ? sub_added : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// rtl/aes_decrypt_core.sv - Iterative AES-128 decryption with forward key generation and k10 cache.
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         key_reuse,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_decrypt_core supports AES-128 only (NR must be 10)");
        end
    endgenerate

    aes_state_t   fsm;
    aes_state_t   fsm_next;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] key_r;
    logic [127:0] k10_cache;
    logic         key_valid;
    logic [127:0] round_out;
    logic [127:0] key_fwd;

    assign key_fwd = fwd_key_step(key_r, rcon(cnt));

    aes_inv_round u_round (
        .state      (st),
        .round_key  (key_r),
        .last_round (fsm == S_FINAL),
        .result     (round_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm <= S_IDLE;
        else        fsm <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            S_IDLE:   if (start) fsm_next = (key_reuse && key_valid) ? S_INIT : S_KEYGEN;
            S_KEYGEN: if (cnt == 4'd10) fsm_next = S_INIT;
            S_INIT:   fsm_next = S_ROUND;
            S_ROUND:  if (cnt == 4'd1) fsm_next = S_FINAL;
            S_FINAL:  fsm_next = S_IDLE;
            default:  fsm_next = S_IDLE;
        endcase
    end

    // cnt counts rcon index up during KEYGEN and the round number down during ROUND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            st        <= '0;
            key_r     <= '0;
            k10_cache <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            plaintext <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        st   <= ciphertext;
                        busy <= 1'b1;
                        if (key_reuse && key_valid) begin
                            key_r <= k10_cache;
                        end else begin
                            key_r <= key;
                            cnt   <= 4'd1;
                        end
                    end
                end
                S_KEYGEN: begin
                    key_r <= key_fwd;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        k10_cache <= key_fwd;
                        key_valid <= 1'b1;
                    end
                end
                S_INIT: begin
                    st    <= st ^ key_r;
                    key_r <= inv_key_step(key_r, rcon(4'd10));
                    cnt   <= 4'd9;
                end
                S_ROUND: begin
                    st    <= round_out;
                    key_r <= inv_key_step(key_r, rcon(cnt));
                    cnt   <= cnt - 4'd1;
                end
                S_FINAL: begin
                    plaintext <= round_out;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb/tb_aes_decrypt_core.sv - Self-checking bench for aes_decrypt_core against a table-driven AES model.
module tb_aes_decrypt_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         key_reuse;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    int checks = 0;
    int failures = 0;

    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [31:0] ws  [44];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 clk = ~clk;

    aes_decrypt_core #(.NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_reuse  (key_reuse),
        .ciphertext (ciphertext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // S-box built by walking generator 3 and its inverse together.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
    endtask

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) ws[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = ws[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            ws[i] = ws[i-4] ^ t;
        end
    endtask

    function automatic logic [127:0] rk(input int r);
        return {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
    endfunction

    task automatic ref_decrypt(input logic [127:0] ct, input logic [127:0] k, output logic [127:0] pt);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] v;
        expand_key(k);
        v = ct ^ rk(10);
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) m[r][c] = v[127-8*(4*c+r) -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r][(c+r)%4] = isb[m[r][c]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) v[127-8*(4*c+r) -: 8] = t[r][c];
            v = v ^ rk(rnd);
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) m[r][c] = v[127-8*(4*c+r) -: 8];
                for (int c = 0; c < 4; c++) begin
                    t[0][c] = gm(m[0][c], 14) ^ gm(m[1][c], 11) ^ gm(m[2][c], 13) ^ gm(m[3][c], 9);
                    t[1][c] = gm(m[0][c], 9)  ^ gm(m[1][c], 14) ^ gm(m[2][c], 11) ^ gm(m[3][c], 13);
                    t[2][c] = gm(m[0][c], 13) ^ gm(m[1][c], 9)  ^ gm(m[2][c], 14) ^ gm(m[3][c], 11);
                    t[3][c] = gm(m[0][c], 11) ^ gm(m[1][c], 13) ^ gm(m[2][c], 9)  ^ gm(m[3][c], 14);
                end
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) v[127-8*(4*c+r) -: 8] = t[r][c];
            end
        end
        pt = v;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Cycle n is the negedge following edge En, where E0 samples start.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] k,
                             input logic reuse, input logic [127:0] exp_pt, input int exp_lat,
                             input bit inject);
        int cyc;
        bit busy_ok;
        int extra_done;
        @(negedge clk);
        start = 1'b1; key_reuse = reuse; ciphertext = ct; key = k;
        @(negedge clk);
        start = 1'b0; ciphertext = rnd128(); key = rnd128();
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (inject && (cyc == 5 || cyc == 15)) begin
                start = 1'b1; key_reuse = 1'b0; ciphertext = ~ct; key = k;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_busy_inflight"}, busy_ok, 1'b1);
        chk({tag, "_busy_low_at_done"}, busy, 1'b0);
        chk({tag, "_plaintext"}, plaintext, exp_pt);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 1'b0);
        if (inject) begin
            extra_done = 0;
            repeat (30) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            chk({tag, "_no_extra_done"}, extra_done, 0);
            chk({tag, "_plaintext_held"}, plaintext, exp_pt);
        end
    endtask

    initial begin
        logic [127:0] rk_key, rct, rpt, ct2, pt2;
        int cyc;
        int late_done;

        build_tables();
        reset = 1'b0; start = 1'b0; key_reuse = 1'b0; ciphertext = '0; key = '0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_plaintext", plaintext, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_block("c1", C1_CT, C1_KEY, 1'b0, C1_PT, 21, 1'b0);
        run_block("appb", B_CT, B_KEY, 1'b0, B_PT, 21, 1'b0);
        chk("appb_k10_cache", dut.k10_cache, B_K10);
        expand_key(B_KEY);
        chk("appb_k10_model", dut.k10_cache, rk(10));
        run_block("appb_reuse", B_CT, {128{1'b1}}, 1'b1, B_PT, 11, 1'b0);

        for (int n = 0; n < 4; n++) begin
            rk_key = rnd128();
            rct    = rnd128();
            ref_decrypt(rct, rk_key, rpt);
            run_block($sformatf("rand%0d", n), rct, rk_key, 1'b0, rpt, 21, 1'b0);
            ct2 = rnd128();
            ref_decrypt(ct2, rk_key, pt2);
            run_block($sformatf("rand%0d_reuse", n), ct2, rnd128(), 1'b1, pt2, 11, 1'b0);
        end

        run_block("busy_reject", C1_CT, C1_KEY, 1'b0, C1_PT, 21, 1'b1);

        @(negedge clk);
        start = 1'b1; key_reuse = 1'b0; ciphertext = C1_CT; key = C1_KEY;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_plaintext", plaintext, '0);
        @(negedge clk);
        reset = 1'b1;
        late_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("midreset_no_done", late_done, 0);
        run_block("post_reset_reuse", B_CT, B_KEY, 1'b1, B_PT, 21, 1'b0);

        @(negedge clk);
        start = 1'b1; key_reuse = 1'b0; ciphertext = C1_CT; key = C1_KEY;
        @(negedge clk);
        ciphertext = B_CT; key = B_KEY;
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_latency", cyc, 21);
        chk("b2b_first_plaintext", plaintext, C1_PT);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accepted", busy, 1'b1);
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_second_latency", cyc, 21);
        chk("b2b_second_plaintext", plaintext, B_PT);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
Iterative AES-128 decryption engine, the inverse counterpart of the encryption top. Accepts a 128-bit ciphertext and cipher key on a start pulse and runs the forward key schedule to obtain round key 10. It then executes the inverse cipher one round per clock, regenerating round keys backwards on the fly. Optionally caches round key 10 so that back-to-back blocks under the same key skip key generation.

Parameters:
NR, 10, number of rounds; AES-128 only, other values unsupported (elaboration error if overridden).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
key_reuse  input  1  with start: reuse cached round key 10 if valid
ciphertext  input  128  block to decrypt; byte 0 = [127:120]; column-major state
key  input  128  cipher key, same byte order; ignored when cached key is used
busy  output  1  high while a block is in flight
done  output  1  single-cycle completion pulse
plaintext  output  128  result; held until next completion

Behaviour:
- Reset (reset low, async): state IDLE; busy=0, done=0, plaintext=0, key_valid=0, cached k10=0, all datapath regs=0. Reset mid-operation aborts the block; no done is issued.
- States: IDLE, KEYGEN, INIT, ROUND, FINAL.
- IDLE: start=1 at edge E0 latches ciphertext and key, sets busy.
  - key_reuse=1 and key_valid=1: go to INIT.
  - Otherwise: go to KEYGEN with rcon index 1.
- KEYGEN: 10 cycles of forward expansion, rcon 01,02,04,08,10,20,40,80,1b,36. On the 10th cycle, store k10 in the cache, set key_valid=1, go to INIT.
- INIT (1 cycle): state <= ciphertext ^ k10; key <= inverse step(k10, rcon[10]) = k9; rnd <= 9; go to ROUND.
- ROUND (9 cycles, rnd 9..1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k_rnd); key <= inverse step(k_rnd, rcon[rnd]); rnd-1. Leave when rnd==1.
- FINAL (1 cycle): plaintext <= InvSubBytes(InvShiftRows(state)) ^ k0; done=1 next cycle; busy=0; go to IDLE.
- Inverse key step, words w0..w3 -> p0..p3:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}.
- Latency from start-sampling edge E0 to done high:
  - 21 cycles with key generation (done registered off edge E21).
  - 11 cycles when the cached key is used.
- done is exactly one cycle wide. busy falls in the same cycle done rises. A new start is accepted on the edge right after done goes high (IDLE).
- start while busy is ignored, with no queueing. ciphertext and key may change freely after E0.
- key_reuse with key_valid=0 behaves as key_reuse=0. key_valid is cleared only by reset; a new KEYGEN overwrites the cache.
- All GF(2^8) arithmetic uses the polynomial 0x11b. InvMixColumns coefficients are 0e, 0b, 0d, 09.

Decomposition:
- Shared package aes_pkg holds:
  - sbox and inv_sbox functions, rcon table (index 1..10), xtime/gmul functions.
  - fwd_key_step and inv_key_step functions.
  - state enum for the FSM.
  - byte-order helpers (byte i of a 128-bit vector).
- One natural sub-module: aes_inv_round. It is combinational: InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, with a last_round input that bypasses InvMixColumns. It is shared by ROUND and FINAL.
- The core contains the FSM, counters, key register, cache register and output registers.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_reuse=0 -> plaintext 00112233445566778899aabbccddeeff; done single pulse 21 cycles after E0; busy high in between.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734. Probe confirms cached k10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key cache: after the App. B block, start with key_reuse=1, key input = all ones, same ct -> same plaintext, done after 11 cycles. After reset, key_reuse=1 -> 21-cycle path with the correct result.
- Busy rejection: pulse start with a different ct at cycles 5 and 15 of a block -> exactly one done, the result of the first block, and plaintext is unchanged afterwards.
- Reset mid-operation: assert reset low in ROUND -> busy=0, done=0 and plaintext=0 immediately (async), no done later. The next start decrypts correctly.
- Back-to-back: start asserted continuously with two C.1/App. B blocks -> second block accepted the cycle after done; both results correct in order.
